// File: rtl/divider_if.sv
// Request/result bundle between the EX stage (master) and the multi-cycle divider (slave).
interface divider_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      signed_div;
    logic [DATA_WIDTH-1:0]     operand1;
    logic [DATA_WIDTH-1:0]     operand2;
    logic                      start;
    logic                      cancel;
    logic [2*DATA_WIDTH-1:0]   result;
    logic                      ready;

    modport master (
        output signed_div, operand1, operand2, start, cancel,
        input  result, ready
    );

    modport slave (
        input  signed_div, operand1, operand2, start, cancel,
        output result, ready
    );
endinterface

// File: rtl/divider.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per clock, result = {remainder, quotient}.
module divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic     clock,
    input  logic     reset,
    divider_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t                  state_r;
    logic [CW-1:0]           count_r;
    logic [2*DATA_WIDTH-1:0] work_r;
    logic [DATA_WIDTH-1:0]   divisor_r;
    logic                    quo_neg_r;
    logic                    rem_neg_r;
    logic [2*DATA_WIDTH-1:0] result_r;
    logic                    ready_r;

    logic [DATA_WIDTH-1:0]   op1_abs_s;
    logic [DATA_WIDTH-1:0]   op2_abs_s;
    logic [2*DATA_WIDTH:0]   shifted_s;
    logic [DATA_WIDTH:0]     diff_s;
    logic [2*DATA_WIDTH-1:0] step_s;
    logic [DATA_WIDTH-1:0]   quo_s;
    logic [DATA_WIDTH-1:0]   rem_s;

    function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
        return ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes, one restoring step and the sign-corrected final values.
    always_comb begin
        op1_abs_s = bus.operand1;
        op2_abs_s = bus.operand2;
        step_s    = '0;
        quo_s     = work_r[DATA_WIDTH-1:0];
        rem_s     = work_r[2*DATA_WIDTH-1:DATA_WIDTH];
        if (bus.signed_div && bus.operand1[DATA_WIDTH-1]) begin
            op1_abs_s = negate(bus.operand1);
        end else begin
            op1_abs_s = bus.operand1;
        end
        if (bus.signed_div && bus.operand2[DATA_WIDTH-1]) begin
            op2_abs_s = negate(bus.operand2);
        end else begin
            op2_abs_s = bus.operand2;
        end
        // The upper DATA_WIDTH+1 bits of the shifted value hold the trial partial remainder.
        shifted_s = {work_r, 1'b0};
        diff_s    = shifted_s[2*DATA_WIDTH:DATA_WIDTH] - {1'b0, divisor_r};
        if (!diff_s[DATA_WIDTH]) begin
            step_s = {diff_s[DATA_WIDTH-1:0], shifted_s[DATA_WIDTH-1:1], 1'b1};
        end else begin
            step_s = shifted_s[2*DATA_WIDTH-1:0];
        end
        if (quo_neg_r) begin
            quo_s = negate(work_r[DATA_WIDTH-1:0]);
        end else begin
            quo_s = work_r[DATA_WIDTH-1:0];
        end
        if (rem_neg_r) begin
            rem_s = negate(work_r[2*DATA_WIDTH-1:DATA_WIDTH]);
        end else begin
            rem_s = work_r[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    // Control FSM with registered result/ready; cancel aborts from any busy state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= FREE;
            count_r   <= '0;
            work_r    <= '0;
            divisor_r <= '0;
            quo_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            result_r  <= '0;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    result_r <= '0;
                    ready_r  <= 1'b0;
                    if (bus.start && !bus.cancel) begin
                        if (bus.operand2 == '0) begin
                            state_r <= BY_ZERO;
                        end else begin
                            state_r   <= ON;
                            count_r   <= '0;
                            divisor_r <= op2_abs_s;
                            work_r    <= {{DATA_WIDTH{1'b0}}, op1_abs_s};
                            quo_neg_r <= bus.signed_div &
                                         (bus.operand1[DATA_WIDTH-1] ^ bus.operand2[DATA_WIDTH-1]);
                            rem_neg_r <= bus.signed_div & bus.operand1[DATA_WIDTH-1];
                        end
                    end else begin
                        state_r <= FREE;
                    end
                end
                BY_ZERO: begin
                    if (bus.cancel) begin
                        state_r <= FREE;
                    end else begin
                        state_r  <= END;
                        result_r <= '0;
                        ready_r  <= 1'b1;
                    end
                end
                ON: begin
                    if (bus.cancel) begin
                        state_r <= FREE;
                        count_r <= '0;
                    end else if (count_r == LAST_COUNT) begin
                        state_r  <= END;
                        count_r  <= '0;
                        result_r <= {rem_s, quo_s};
                        ready_r  <= 1'b1;
                    end else begin
                        work_r  <= step_s;
                        count_r <= count_r + CW'(1);
                    end
                end
                END: begin
                    if (!bus.start || bus.cancel) begin
                        state_r  <= FREE;
                        result_r <= '0;
                        ready_r  <= 1'b0;
                    end else begin
                        state_r <= END;
                    end
                end
                default: begin
                    state_r  <= FREE;
                    count_r  <= '0;
                    result_r <= '0;
                    ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result = result_r;
    assign bus.ready  = ready_r;
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results queued at request time, compared when ready rises.
module tb_divider;
    logic clock;
    logic reset;
    int   total_checks;
    int   fail_checks;
    logic [63:0] exp_q[$];

    divider_if #(.DATA_WIDTH(32)) bus ();

    divider #(.DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_checks++;
        if (obs !== expv) begin
            fail_checks++;
            $display("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
    endfunction

    // Issue one request, scramble operands after the start edge, then check latency, result, hold and release.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input int lat, input int hold);
        int n;
        logic got;
        logic [63:0] e;
        exp_q.push_back(expv);
        @(negedge clock);
        bus.signed_div = sgn;
        bus.operand1   = a;
        bus.operand2   = b;
        bus.start      = 1'b1;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (bus.ready) begin
                got = 1'b1;
                break;
            end
            n++;
            if (i == 0) begin
                bus.operand1   = $urandom;
                bus.operand2   = $urandom;
                bus.signed_div = ~sgn;
            end
        end
        e = exp_q.pop_front();
        check_eq("ready_seen", {63'd0, got}, 64'd1);
        check_eq("latency", 64'(n), 64'(lat));
        check_eq("result", bus.result, e);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock);
            #1;
            check_eq("hold_result", bus.result, e);
            check_eq("hold_ready", {63'd0, bus.ready}, 64'd1);
        end
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock);
        #1;
        check_eq("release_ready", {63'd0, bus.ready}, 64'd0);
        check_eq("release_result", bus.result, 64'd0);
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        total_checks = 0;
        fail_checks  = 0;
        bus.signed_div = 1'b0;
        bus.operand1   = 32'd0;
        bus.operand2   = 32'd0;
        bus.start      = 1'b0;
        bus.cancel     = 1'b0;
        reset = 1'b0;
        #12;
        check_eq("reset_ready", {63'd0, bus.ready}, 64'd0);
        check_eq("reset_result", bus.result, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 33, 0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 33, 0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0000_0000, 32'hFFFF_FFFF}, 33, 5);
        do_div(1'b1, 32'd1234, 32'd0, 64'd0, 1, 0);

        // Cancel on the 10th ON cycle: no result ever appears.
        @(negedge clock);
        bus.signed_div = 1'b0;
        bus.operand1   = 32'd1000;
        bus.operand2   = 32'd3;
        bus.start      = 1'b1;
        @(posedge clock);
        repeat (9) @(posedge clock);
        @(negedge clock);
        bus.cancel = 1'b1;
        bus.start  = 1'b0;
        @(negedge clock);
        bus.cancel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.ready) check_eq("cancel_no_ready", {63'd0, bus.ready}, 64'd0);
        end
        check_eq("cancel_result", bus.result, 64'd0);
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        // Cancel together with start in FREE: request is refused while cancel holds.
        @(negedge clock);
        bus.operand1 = 32'd50;
        bus.operand2 = 32'd5;
        bus.start    = 1'b1;
        bus.cancel   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.ready) check_eq("start_cancel_ready", {63'd0, bus.ready}, 64'd0);
        end
        @(negedge clock);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        @(negedge clock);

        // Asynchronous reset mid-ON and in END, then immediate new request.
        bus.operand1 = 32'd77;
        bus.operand2 = 32'd5;
        bus.start    = 1'b1;
        repeat (6) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_eq("rst_on_ready", {63'd0, bus.ready}, 64'd0);
        check_eq("rst_on_result", bus.result, 64'd0);
        @(negedge clock);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        bus.start = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check_eq("pre_rst_end_ready", {63'd0, bus.ready}, 64'd1);
        check_eq("pre_rst_end_result", bus.result, {32'd2, 32'd15});
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_end_ready", {63'd0, bus.ready}, 64'd0);
        check_eq("rst_end_result", bus.result, 64'd0);
        @(negedge clock);
        bus.start = 1'b0;
        reset     = 1'b1;
        do_div(1'b0, 32'd200, 32'd9, {32'd2, 32'd22}, 33, 0);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k == 5) ? 32'd3 : $urandom_range(1, 70000);
            rs = k[0];
            do_div(rs, ra, rb, ref_div(rs, ra, rb), 33, 0);
        end

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end
endmodule
